rvc_asap_eot_monitor: RTL and testbench
=======================================

# rvc_asap_eot_monitor

Synthesizable end-of-test monitor for the rvc_asap core, placed in rvc_top next to rvc_mem_wrap. It watches the retiring instruction stream for ebreak (and optionally ecall), and enforces a cycle timeout. On any end condition it halts the core and streams a window of data memory out over a valid/ready port, one word per beat. Benches and FPGA debug logic use that stream as the memory snapshot.

## Interface
- D_MEM_OFFSET, 'h1000: byte address of the first snapshot word; must be 4-byte aligned.
- SNAP_WORDS, 1024: number of 32-bit words dumped; must be ≥1.
- TIMEOUT_CYCLES, 1000: cycles in RUN before a forced end; 0 disables the timeout.
- EN_ECALL, 0: 1 makes ecall an end condition as well.
- ADDR_W, 32: width of MemRdAddr and SnapAddr.

Ports:
- Clock  in  1  sole clock, rising edge.
- Rst  in  1  reset; synchronous, active-high.
- InstrValid  in  1  Instruction is a retiring instruction this cycle.
- Instruction  in  32  retiring instruction word.
- Halt  out  1  stall request to the core.
- MemRdEn  out  1  data-memory read strobe.
- MemRdAddr  out  ADDR_W  word-aligned byte address.
- MemRdData  in  32  read data; valid the cycle after MemRdEn.
- SnapValid  out  1  snapshot beat valid.
- SnapReady  in  1  consumer accepts the beat.
- SnapAddr  out  ADDR_W  byte address of the beat.
- SnapData  out  32  memory word at SnapAddr.
- EndCause  out  2  0=NONE, 1=EBREAK, 2=ECALL, 3=TIMEOUT.
- CycleCnt  out  32  cycles spent in RUN; saturates at all-ones and freezes once RUN is left.
- Done  out  1  all SNAP_WORDS beats accepted; sticky until reset.

## Operation
- States:
  - RUN: counts cycles and watches for end conditions.
  - RD: MemRdEn=1, MemRdAddr=D_MEM_OFFSET+4*idx.
  - CAP: registers MemRdData into SnapData.
  - SEND: SnapValid=1.
  - DONE.
- End detection, evaluated in RUN only:
  - EBREAK: InstrValid && Instruction==32'h00100073.
  - ECALL: EN_ECALL && InstrValid && Instruction==32'h00000073.
  - TIMEOUT: TIMEOUT_CYCLES!=0 && CycleCnt==TIMEOUT_CYCLES-1.
- Priority when several conditions hold in the same cycle: EBREAK > ECALL > TIMEOUT.
- When an end condition is detected:
  - EndCause is latched.
  - Halt is set and held high until reset.
  - idx is cleared and the FSM moves RUN→RD.
- Dump loop:
  - RD→CAP→SEND unconditionally.
  - SEND holds while SnapReady=0. SnapAddr and SnapData stay stable.
  - On a handshake (SnapValid&&SnapReady) with idx<SNAP_WORDS-1: increment idx, go to RD.
  - On a handshake with idx==SNAP_WORDS-1: go to DONE and set Done.
- DONE is terminal. Further instructions, including another ebreak, are ignored.
- idx width: $clog2(SNAP_WORDS), minimum 1. Address arithmetic is done in ADDR_W bits and wraps modulo 2^ADDR_W.
- Reset values: state=RUN, Halt=0, MemRdEn=0, MemRdAddr=0, SnapValid=0, SnapAddr=0, SnapData=0, EndCause=NONE, CycleCnt=0, Done=0, idx=0.
- Rst in any state, including mid-dump, restores all reset values on the next edge. A beat that has not yet been handshaken is dropped.

## Timing
- End instruction seen in cycle T:
  - Halt=1 and EndCause are valid from T+1.
  - MemRdEn=1 in T+1.
  - First SnapValid in T+3.
- With SnapReady held at 1, there is one beat every 3 cycles. The last handshake occurs at T+3*SNAP_WORDS, and Done=1 from the following cycle.
- CycleCnt increments on every RUN cycle after reset. It holds its value from T+1.
- Timeout with TIMEOUT_CYCLES=N: the end condition fires in the N-th RUN cycle after reset deassertion (CycleCnt==N-1).
- Only one read is ever outstanding. MemRdEn is high only in RD.
- SnapValid is never deasserted before its handshake.

## Structure
- rvc_asap_pkg additions:
  - EBREAK_INSTR, ECALL_INSTR constants.
  - t_eot_cause enum, 2 bits.
  - t_eot_state enum: RUN/RD/CAP/SEND/DONE.
- No sub-module is needed; the counters and FSM are inline.
- All flops are built with the codebase's sync-reset RVC_MSFF-style macros.

## Test plan
1. SNAP_WORDS=4, D_MEM words at 0x1000..0x100C = 11111111/22222222/33333333/44444444, ebreak at cycle 20, SnapReady=1 -> Halt from cycle 21; 4 beats with SnapAddr 0x1000, 0x1004, 0x1008, 0x100C carrying the matching data; EndCause=1; Done=1; CycleCnt=20.
2. TIMEOUT_CYCLES=50, no end instruction -> EndCause=3, CycleCnt frozen at 50, dump completes.
3. SnapReady driven by a random 30%-high pattern -> every beat's addr/data is stable until its handshake, no beat is lost or duplicated, and the beat order is preserved.
4. ecall with EN_ECALL=0 -> ignored, stays in RUN. Same stimulus with EN_ECALL=1 -> EndCause=2.
5. ebreak in the exact cycle the timeout fires -> EndCause=1. InstrValid=0 with Instruction=00100073 -> no end.
6. Rst asserted during SEND of beat 2 -> next cycle all outputs at reset values. A fresh ebreak then produces a full dump starting at 0x1000.

Source files
------------

// File: rtl/rvc_asap_eot_monitor_pkg.sv
// ---------------------------------------------------------------------------
// rvc_asap_eot_monitor_pkg
// Shared constants and types for the end-of-test monitor.
//   EBREAK_INSTR / ECALL_INSTR : instruction encodings that end a test
//   t_eot_cause                : 2-bit end-cause code exposed on EndCause
//   t_eot_state                : monitor FSM states
// ---------------------------------------------------------------------------
package rvc_asap_eot_monitor_pkg;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_EBREAK  = 2'd1,
        CAUSE_ECALL   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } t_eot_cause;

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } t_eot_state;

endpackage

// File: rtl/rvc_asap_eot_monitor_if.sv
// ---------------------------------------------------------------------------
// rvc_asap_eot_monitor_if
// Snapshot stream: one data-memory word per valid/ready beat.
//   SnapValid : beat valid (producer)
//   SnapReady : beat accepted (consumer)
//   SnapAddr  : byte address of the word
//   SnapData  : memory word at SnapAddr
// master = the monitor, slave = the consumer (bench / debug logic).
// ---------------------------------------------------------------------------
interface rvc_asap_eot_monitor_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              SnapValid;
    logic              SnapReady;
    logic [ADDR_W-1:0] SnapAddr;
    logic [31:0]       SnapData;

    modport master (
        output SnapValid,
        output SnapAddr,
        output SnapData,
        input  SnapReady
    );

    modport slave (
        input  SnapValid,
        input  SnapAddr,
        input  SnapData,
        output SnapReady
    );

endinterface

// File: rtl/rvc_asap_eot_monitor.sv
// ---------------------------------------------------------------------------
// rvc_asap_eot_monitor
// Watches retiring instructions for ebreak (optionally ecall) and enforces a
// RUN-cycle timeout. On an end condition it halts the core and streams
// SNAP_WORDS data-memory words starting at D_MEM_OFFSET over the snap port.
// Ports:
//   Clock, Rst            : clock, synchronous active-high reset
//   InstrValid/Instruction: retiring instruction stream
//   Halt                  : stall request, high from end detection to reset
//   MemRdEn/MemRdAddr     : data-memory read request (one outstanding)
//   MemRdData             : read data, valid the cycle after MemRdEn
//   snap                  : snapshot stream (valid/ready, addr, data)
//   EndCause              : NONE/EBREAK/ECALL/TIMEOUT
//   CycleCnt              : saturating count of RUN cycles
//   Done                  : all beats accepted, sticky until reset
// ---------------------------------------------------------------------------
module rvc_asap_eot_monitor
    import rvc_asap_eot_monitor_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] D_MEM_OFFSET   = 'h1000,
    parameter int unsigned       SNAP_WORDS     = 1024,
    parameter int unsigned       TIMEOUT_CYCLES = 1000,
    parameter bit                EN_ECALL       = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  InstrValid,
    input  logic [31:0]           Instruction,
    output logic                  Halt,
    output logic                  MemRdEn,
    output logic [ADDR_W-1:0]     MemRdAddr,
    input  logic [31:0]           MemRdData,
    rvc_asap_eot_monitor_if.master snap,
    output logic [1:0]            EndCause,
    output logic [31:0]           CycleCnt,
    output logic                  Done
);

    localparam int unsigned      IDX_W        = (SNAP_WORDS > 1) ? $clog2(SNAP_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(SNAP_WORDS - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    t_eot_state        state;
    t_eot_state        state_nxt;
    t_eot_cause        cause;
    t_eot_cause        cause_nxt;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       cycle_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] snap_addr;
    logic [31:0]       snap_data;
    logic              snap_valid;
    logic              handshake;
    logic              is_ebreak;
    logic              is_ecall;
    logic              is_tmo;

    // Address wraps modulo 2^ADDR_W by construction of the ADDR_W-bit sum.
    assign rd_addr    = D_MEM_OFFSET + (ADDR_W'(idx) << 2);
    assign snap_valid = (state == S_SEND);
    assign handshake  = snap_valid && snap.SnapReady;

    assign is_ebreak = InstrValid && (Instruction == EBREAK_INSTR);
    assign is_ecall  = EN_ECALL && InstrValid && (Instruction == ECALL_INSTR);
    assign is_tmo    = (TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt = state;
        cause_nxt = CAUSE_NONE;
        case (state)
            S_RUN: begin
                if (is_ebreak)     cause_nxt = CAUSE_EBREAK;
                else if (is_ecall) cause_nxt = CAUSE_ECALL;
                else if (is_tmo)   cause_nxt = CAUSE_TIMEOUT;
                if (cause_nxt != CAUSE_NONE) state_nxt = S_RD;
            end
            S_RD:   state_nxt = S_CAP;
            S_CAP:  state_nxt = S_SEND;
            S_SEND: begin
                if (handshake) state_nxt = (idx == LAST_IDX) ? S_DONE : S_RD;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state     <= S_RUN;
            cause     <= CAUSE_NONE;
            idx       <= '0;
            cycle_cnt <= '0;
            snap_addr <= '0;
            snap_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RUN) begin
                // cause_nxt is NONE unless this is the cycle RUN is left,
                // so the value latched on exit is what persists.
                cause <= cause_nxt;
                idx   <= '0;
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
            end
            if ((state == S_SEND) && handshake && (idx != LAST_IDX)) begin
                idx <= idx + 1'b1;
            end
            // idx is unchanged between RD and CAP, so rd_addr is the address
            // that was read in the previous cycle.
            if (state == S_CAP) begin
                snap_addr <= rd_addr;
                snap_data <= MemRdData;
            end
        end
    end

    assign Halt           = (state != S_RUN);
    assign MemRdEn        = (state == S_RD);
    assign MemRdAddr      = MemRdEn ? rd_addr : '0;
    assign snap.SnapValid = snap_valid;
    assign snap.SnapAddr  = snap_addr;
    assign snap.SnapData  = snap_data;
    assign EndCause       = cause;
    assign CycleCnt       = cycle_cnt;
    assign Done           = (state == S_DONE);

endmodule

// File: tb/tb_rvc_asap_eot_monitor.sv
// ---------------------------------------------------------------------------
// tb_rvc_asap_eot_monitor
// Directed bench for the end-of-test monitor. dut_a (SNAP_WORDS=4,
// TIMEOUT_CYCLES=50, EN_ECALL=1) carries the dump scenarios; dut_b
// (TIMEOUT_CYCLES=0, EN_ECALL=0) shares the instruction stream to show that
// ecall and the timeout are ignored when disabled. Stimulus pushes expected
// beats and end records; a monitor process pops them on each handshake and
// on the rising edge of Done.
// ---------------------------------------------------------------------------
module tb_rvc_asap_eot_monitor;
    import rvc_asap_eot_monitor_pkg::*;

    logic        Clock = 1'b0;
    logic        Rst;
    logic        InstrValid;
    logic [31:0] Instruction;

    logic        halt_a, rden_a, done_a;
    logic [31:0] rdaddr_a, cyc_a;
    logic [31:0] rddata_a = '0;
    logic [1:0]  cause_a;

    logic        halt_b, rden_b, done_b;
    logic [31:0] rdaddr_b, cyc_b;
    logic [31:0] rddata_b;
    logic [1:0]  cause_b;

    rvc_asap_eot_monitor_if #(.ADDR_W(32)) snap_a ();
    rvc_asap_eot_monitor_if #(.ADDR_W(32)) snap_b ();

    always #5 Clock = ~Clock;

    rvc_asap_eot_monitor #(
        .ADDR_W(32), .D_MEM_OFFSET(32'h1000), .SNAP_WORDS(4),
        .TIMEOUT_CYCLES(50), .EN_ECALL(1'b1)
    ) dut_a (
        .Clock(Clock), .Rst(Rst), .InstrValid(InstrValid), .Instruction(Instruction),
        .Halt(halt_a), .MemRdEn(rden_a), .MemRdAddr(rdaddr_a), .MemRdData(rddata_a),
        .snap(snap_a), .EndCause(cause_a), .CycleCnt(cyc_a), .Done(done_a)
    );

    rvc_asap_eot_monitor #(
        .ADDR_W(32), .D_MEM_OFFSET(32'h1000), .SNAP_WORDS(4),
        .TIMEOUT_CYCLES(0), .EN_ECALL(1'b0)
    ) dut_b (
        .Clock(Clock), .Rst(Rst), .InstrValid(InstrValid), .Instruction(Instruction),
        .Halt(halt_b), .MemRdEn(rden_b), .MemRdAddr(rdaddr_b), .MemRdData(rddata_b),
        .snap(snap_b), .EndCause(cause_b), .CycleCnt(cyc_b), .Done(done_b)
    );

    assign rddata_b         = 32'h0;
    assign snap_b.SnapReady = 1'b0;

    // Data memory behind dut_a: word k above 0x1000 holds 0x11111111*(k+1).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = (a - 32'h1000) >> 2;
        return 32'h1111_1111 * (k + 32'd1);
    endfunction

    always @(posedge Clock) begin
        if (rden_a) rddata_a <= mem_word(rdaddr_a);
    end

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic rand_mode = 1'b0;

    logic [31:0] exp_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [31:0] q_addr  [$];
    logic [31:0] q_data  [$];
    logic [1:0]  q_cause [$];
    logic [31:0] q_cnt   [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            q_addr.push_back(32'h1000 + 32'(4 * i));
            q_data.push_back(exp_data[i]);
        end
    endtask

    task automatic push_end(input logic [1:0] cause, input logic [31:0] cnt);
        q_cause.push_back(cause);
        q_cnt.push_back(cnt);
    endtask

    // One clock per call; cyc numbers RUN cycles from 1 after reset release.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            cyc++;
            if (rand_mode) snap_a.SnapReady = ($urandom_range(0, 9) < 3);
        end
    endtask

    task automatic goto_cycle(input int k);
        if (k > cyc) step(k - cyc);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Rst         = 1'b1;
        InstrValid  = 1'b0;
        Instruction = 32'h0;
        @(negedge Clock);
        Rst = 1'b0;
        cyc = 1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic v);
        InstrValid  = v;
        Instruction = ins;
        step(1);
        InstrValid  = 1'b0;
        Instruction = 32'h0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_a && n < 400) begin
            step(1);
            n++;
        end
        chk({name, " done reached"}, 32'(done_a), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " Halt"},      32'(halt_a),           32'd0);
        chk({tag, " MemRdEn"},   32'(rden_a),           32'd0);
        chk({tag, " MemRdAddr"}, rdaddr_a,              32'h0);
        chk({tag, " SnapValid"}, 32'(snap_a.SnapValid), 32'd0);
        chk({tag, " SnapAddr"},  snap_a.SnapAddr,       32'h0);
        chk({tag, " SnapData"},  snap_a.SnapData,       32'h0);
        chk({tag, " EndCause"},  32'(cause_a),          32'd0);
        chk({tag, " CycleCnt"},  cyc_a,                 32'd0);
        chk({tag, " Done"},      32'(done_a),           32'd0);
    endtask

    // Monitor: samples just after the falling edge, i.e. the values that the
    // next rising edge will act on.
    logic        pend      = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pend_data = '0;

    always begin
        @(negedge Clock);
        #1;
        if (Rst) begin
            pend      = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (pend) begin
                chk("hold valid", 32'(snap_a.SnapValid), 32'd1);
                chk("hold addr",  snap_a.SnapAddr, pend_addr);
                chk("hold data",  snap_a.SnapData, pend_data);
            end
            if (snap_a.SnapValid && snap_a.SnapReady) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected beat", snap_a.SnapAddr, 32'hFFFF_FFFF);
                end else begin
                    chk("beat addr", snap_a.SnapAddr, q_addr.pop_front());
                    chk("beat data", snap_a.SnapData, q_data.pop_front());
                end
                pend = 1'b0;
            end else if (snap_a.SnapValid) begin
                pend      = 1'b1;
                pend_addr = snap_a.SnapAddr;
                pend_data = snap_a.SnapData;
            end else begin
                pend = 1'b0;
            end
            if (done_a && !prev_done) begin
                if (q_cause.size() == 0) begin
                    chk("unexpected done", 32'(done_a), 32'd0);
                end else begin
                    chk("end cause", 32'(cause_a), 32'(q_cause.pop_front()));
                    chk("end cyclecnt", cyc_a, q_cnt.pop_front());
                end
                chk("beats drained at done", 32'(q_addr.size()), 32'd0);
            end
            prev_done = done_a;
        end
    end

    initial begin
        Rst              = 1'b1;
        InstrValid       = 1'b0;
        Instruction      = 32'h0;
        snap_a.SnapReady = 1'b1;

        do_reset();
        check_reset_vals("por");

        // ecall at cycle 5: dut_a ends (ECALL), dut_b ignores it
        push_beats(4);
        push_end(2'd2, 32'd5);
        goto_cycle(5);
        issue(ECALL_INSTR, 1'b1);
        chk("ecall a Halt",     32'(halt_a),  32'd1);
        chk("ecall a EndCause", 32'(cause_a), 32'd2);
        chk("ecall b Halt",     32'(halt_b),  32'd0);
        chk("ecall b EndCause", 32'(cause_b), 32'd0);
        wait_done("ecall");
        goto_cycle(60);
        chk("no timeout b Halt",     32'(halt_b), 32'd0);
        chk("no timeout b CycleCnt", cyc_b,       32'd59);

        // ebreak at cycle 20, ready held high: exact timing
        do_reset();
        push_beats(4);
        push_end(2'd1, 32'd20);
        goto_cycle(20);
        chk("pre-ebreak Halt", 32'(halt_a), 32'd0);
        issue(EBREAK_INSTR, 1'b1);
        chk("T+1 Halt",      32'(halt_a),  32'd1);
        chk("T+1 MemRdEn",   32'(rden_a),  32'd1);
        chk("T+1 MemRdAddr", rdaddr_a,     32'h1000);
        chk("T+1 EndCause",  32'(cause_a), 32'd1);
        step(1);
        chk("T+2 SnapValid", 32'(snap_a.SnapValid), 32'd0);
        chk("T+2 MemRdEn",   32'(rden_a),           32'd0);
        step(1);
        chk("T+3 SnapValid", 32'(snap_a.SnapValid), 32'd1);
        step(9);
        chk("T+12 Done", 32'(done_a), 32'd0);
        step(1);
        chk("T+13 Done",     32'(done_a), 32'd1);
        chk("T+13 CycleCnt", cyc_a,       32'd20);
        issue(EBREAK_INSTR, 1'b1);
        step(3);
        chk("post-done Done",      32'(done_a),           32'd1);
        chk("post-done EndCause",  32'(cause_a),          32'd1);
        chk("post-done SnapValid", 32'(snap_a.SnapValid), 32'd0);
        chk("post-done CycleCnt",  cyc_a,                 32'd20);

        // ebreak with InstrValid=0 is ignored; timeout fires at cycle 50
        do_reset();
        push_beats(4);
        push_end(2'd3, 32'd50);
        goto_cycle(10);
        issue(EBREAK_INSTR, 1'b0);
        chk("invalid ebreak Halt", 32'(halt_a), 32'd0);
        goto_cycle(50);
        chk("cycle 50 pre Halt", 32'(halt_a), 32'd0);
        wait_done("timeout");

        // ebreak in the timeout cycle wins
        do_reset();
        push_beats(4);
        push_end(2'd1, 32'd50);
        goto_cycle(50);
        issue(EBREAK_INSTR, 1'b1);
        wait_done("ebreak vs timeout");

        // random backpressure (~30% ready)
        do_reset();
        rand_mode = 1'b1;
        push_beats(4);
        push_end(2'd1, 32'd3);
        goto_cycle(3);
        issue(EBREAK_INSTR, 1'b1);
        wait_done("backpressure");
        rand_mode        = 1'b0;
        snap_a.SnapReady = 1'b1;

        // reset during SEND of beat 2, then a fresh full dump
        do_reset();
        push_beats(1);
        goto_cycle(2);
        issue(EBREAK_INSTR, 1'b1);
        step(5);
        chk("beat2 SnapValid", 32'(snap_a.SnapValid), 32'd1);
        chk("beat2 SnapAddr",  snap_a.SnapAddr,       32'h1004);
        Rst = 1'b1;
        step(1);
        check_reset_vals("mid-dump rst");
        chk("beat queue after rst", 32'(q_addr.size()), 32'd0);
        Rst = 1'b0;
        cyc = 1;
        push_beats(4);
        push_end(2'd1, 32'd4);
        goto_cycle(4);
        issue(EBREAK_INSTR, 1'b1);
        wait_done("after rst");

        step(3);
        chk("end records drained", 32'(q_cause.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
